// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: 8-source edge-capturing interrupt controller.
// Raw irq lines are synchronised, rising edges are latched into a pending
// register, the highest-priority unmasked source is granted, and a
// req/ack/eoi handshake is run with a single consumer.
// Optional build macro IRQ_ROUND_ROBIN_EN replaces fixed priority (bit 7
// highest) with a rotating order in which the last acknowledged source
// becomes the lowest priority.
// SYNC_STAGES: synchroniser depth per irq line, legal range 1..3.

module irq_prio_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] irq,
  input  logic [7:0] mask,
  input  logic       ack,
  input  logic       eoi,
  output logic       int_req,
  output logic [2:0] int_id,
  output logic [7:0] pending,
  output logic       in_service
);

  localparam int unsigned N_IRQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Fixed priority encode: highest set bit wins.
  function automatic logic [ID_W-1:0] enc_fixed(input logic [N_IRQ-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  // Rotating priority encode: scans from ptr (lowest) to ptr-1 (highest).
  function automatic logic [ID_W-1:0] enc_rot(input logic [N_IRQ-1:0] v,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] r;
    logic [ID_W-1:0] idx;
    r = '0;
    for (int k = 0; k < int'(N_IRQ); k++) begin
      idx = ptr + ID_W'(k);
      if (v[idx]) r = idx;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Capture path: synchroniser, history flop, edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;
  logic [N_IRQ-1:0]                  hist_q, hist_d;
  logic [N_IRQ-1:0]                  sync_out_c;
  logic [N_IRQ-1:0]                  edge_c;

  generate
    if (SYNC_STAGES == 1) begin : g_sync1
      // Single-stage synchroniser: only the raw line is shifted in.
      always_comb begin
        sync_d = irq;
      end
    end else begin : g_syncn
      // Multi-stage synchroniser: shift the raw line into stage 0.
      always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq};
      end
    end
  endgenerate

  // History flop follows the synchroniser output; edge = new 1 over old 0.
  always_comb begin
    sync_out_c = sync_q[SYNC_STAGES-1];
    hist_d     = sync_out_c;
    edge_c     = sync_out_c & ~hist_q;
  end

  // ---------------------------------------------------------------------
  // Selection and FSM
  // ---------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              int_req_q, int_req_d;
  logic [ID_W-1:0]   int_id_q, int_id_d;
  logic              in_service_q, in_service_d;
  logic [N_IRQ-1:0]  pending_q, pending_d;
  logic [N_IRQ-1:0]  sel_c;
  logic [ID_W-1:0]   grant_id_c;
  logic              ack_take_c;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]   ptr_q, ptr_d;

  // Rotating arbitration; ptr marks the lowest-priority source.
  always_comb begin
    sel_c      = pending_q & ~mask;
    grant_id_c = enc_rot(sel_c, ptr_q);
  end

  // The acknowledged source drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (ack_take_c) ptr_d = int_id_q;
  end
`else
  // Fixed arbitration, bit 7 highest.
  always_comb begin
    sel_c      = pending_q & ~mask;
    grant_id_c = enc_fixed(sel_c);
  end
`endif

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    ack_take_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && (sel_c != '0)) begin
          int_id_d  = grant_id_c;
          int_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // int_id stays frozen here; ack beats eoi and a falling en.
        if (ack) begin
          ack_take_c   = 1'b1;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = ST_SERVICE;
        end else if (!en) begin
          int_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        // Service runs to eoi regardless of en.
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // Pending update: ack clears the granted bit, a same-cycle edge re-sets it.
  always_comb begin
    pending_d = pending_q;
    if (ack_take_c) pending_d[int_id_q] = 1'b0;
    if (en)         pending_d = pending_d | edge_c;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // Capture-path flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // FSM, outputs and pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      int_req_q    <= 1'b0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
      pending_q    <= pending_d;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  // Round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign int_req    = int_req_q;
  assign int_id     = int_id_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
